// File: rtl/gate_vector_sequencer_if.sv
// Gate-side and status bundle for gate_vector_sequencer.
// GATE_SEQ_SIGNATURE_EN adds the 16-bit response signature sig_o.
interface gate_vector_sequencer_if #(
  parameter int WIDTH = 2
);
  logic             start;
  logic             resp_i;
  logic [WIDTH-1:0] vec_o;
  logic             busy;
  logic             done;
  logic             pass;
  logic [WIDTH:0]   err_cnt;
  logic [WIDTH-1:0] first_fail;
`ifdef GATE_SEQ_SIGNATURE_EN
  logic [15:0]      sig_o;

  modport master (input start, resp_i,
                  output vec_o, busy, done, pass, err_cnt, first_fail, sig_o);
  modport slave  (output start, resp_i,
                  input vec_o, busy, done, pass, err_cnt, first_fail, sig_o);
`else
  modport master (input start, resp_i,
                  output vec_o, busy, done, pass, err_cnt, first_fail);
  modport slave  (output start, resp_i,
                  input vec_o, busy, done, pass, err_cnt, first_fail);
`endif
endinterface

// File: rtl/gate_vector_sequencer.sv
// Exhaustive gate stimulus/check sequencer: walks all 2**WIDTH input vectors,
// holds each SETTLE cycles, samples the gate response and compares it to TRUTH.
// Optional: GATE_SEQ_SIGNATURE_EN compiles in a 16-bit response LFSR on sig_o.
module gate_vector_sequencer #(
  parameter int                    WIDTH  = 2,
  parameter int                    SETTLE = 1,
  parameter logic [(1<<WIDTH)-1:0] TRUTH  = 4'b1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  gate_vector_sequencer_if.master bus
);
  localparam int               CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] VEC_LAST = '1;
  localparam logic [WIDTH-1:0] VEC_ONE  = WIDTH'(1);
  localparam logic [WIDTH:0]   ERR_ONE  = (WIDTH+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   err_q, err_d;
  logic [WIDTH-1:0] ff_q, ff_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             mism;

  assign mism = bus.resp_i ^ TRUTH[vec_q];

`ifdef GATE_SEQ_SIGNATURE_EN
  logic [15:0] sig_q, sig_d;
  logic        sig_fb;
  // x^16+x^12+x^5+1 taps, response folded into the feedback bit
  assign sig_fb = sig_q[15] ^ sig_q[11] ^ sig_q[4] ^ bus.resp_i;
  assign bus.sig_o = sig_q;
`endif

  // State and datapath registers; reset discards any partial sweep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      ff_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef GATE_SEQ_SIGNATURE_EN
      sig_q   <= 16'hFFFF;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
`ifdef GATE_SEQ_SIGNATURE_EN
      sig_q   <= sig_d;
`endif
    end
  end

  // Next-state: start is only honoured from IDLE/DONE, so mid-sweep starts vanish
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ff_d    = ff_q;
    done_d  = done_q;
    pass_d  = pass_q;
`ifdef GATE_SEQ_SIGNATURE_EN
    sig_d   = sig_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_DRIVE;
          vec_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          ff_d    = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
`ifdef GATE_SEQ_SIGNATURE_EN
          sig_d   = 16'hFFFF;
`endif
        end
      end
      S_DRIVE: begin
        if (cnt_q == CNT_LAST) state_d = S_SAMPLE;
        else                   cnt_d   = cnt_q + CNT_ONE;
      end
      S_SAMPLE: begin
        if (mism) begin
          err_d = err_q + ERR_ONE;
          if (err_q == '0) ff_d = vec_q;
        end
`ifdef GATE_SEQ_SIGNATURE_EN
        sig_d = {sig_q[14:0], sig_fb};
`endif
        if (vec_q == VEC_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          state_d = S_DRIVE;
          vec_d   = vec_q + VEC_ONE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_DRIVE) || (state_d == S_SAMPLE);
  end

  assign bus.vec_o      = vec_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_cnt    = err_q;
  assign bus.first_fail = ff_q;
endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Bench for gate_vector_sequencer (default WIDTH=2, SETTLE=1, TRUTH=AND).
// Define GATE_SEQ_SIGNATURE_EN to also check sig_o.
module tb_gate_vector_sequencer;
  localparam int              W = 2;
  localparam int              S = 1;
  localparam int              N = 1 << W;
  localparam logic [N-1:0]    T = 4'b1000;

  logic       clk;
  logic       rst_n;
  logic [N-1:0] gate_fn;
  int         total = 0;
  int         bad   = 0;

  gate_vector_sequencer_if #(.WIDTH(W)) bus ();

  gate_vector_sequencer #(.WIDTH(W), .SETTLE(S), .TRUTH(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // gate under test: arbitrary truth table selected by the bench
  assign bus.resp_i = gate_fn[bus.vec_o];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference: mismatches against T, lowest failing vector, LFSR signature
  task automatic model(input logic [N-1:0] g, output int errs, output int ff,
                       output logic [15:0] sig);
    logic fb;
    errs = 0;
    ff   = 0;
    sig  = 16'hFFFF;
    for (int v = 0; v < N; v++) begin
      if (g[v] != T[v]) begin
        if (errs == 0) ff = v;
        errs++;
      end
      fb  = sig[15] ^ sig[11] ^ sig[4] ^ g[v];
      sig = {sig[14:0], fb};
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_vec"},  32'(bus.vec_o), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_pass"}, 32'(bus.pass), 0);
    chk({tag, "_err"},  32'(bus.err_cnt), 0);
    chk({tag, "_ff"},   32'(bus.first_fail), 0);
`ifdef GATE_SEQ_SIGNATURE_EN
    chk({tag, "_sig"},  32'(bus.sig_o), 32'hFFFF);
`endif
  endtask

  // one full sweep with gate g; optionally re-pulse start mid-sweep
  task automatic sweep(input string tag, input logic [N-1:0] g, input bit ign);
    int errs, ff;
    logic [15:0] sig;
    model(g, errs, ff, sig);
    gate_fn = g;
    @(negedge clk);
    bus.start = 1'b1;
    for (int i = 0; i <= N * (S + 1); i++) begin
      @(negedge clk);
      bus.start = ign && (i == 2);
      if (i == 0) chk({tag, "_err_clr"}, 32'(bus.err_cnt), 0);
      if (i < N * (S + 1)) begin
        chk({tag, "_vec"},  32'(bus.vec_o), 32'(i / (S + 1)));
        chk({tag, "_busy"}, 32'(bus.busy), 1);
        chk({tag, "_done"}, 32'(bus.done), 0);
      end else begin
        chk({tag, "_vec_end"},  32'(bus.vec_o), 32'(N - 1));
        chk({tag, "_busy_end"}, 32'(bus.busy), 0);
        chk({tag, "_done_end"}, 32'(bus.done), 1);
      end
    end
    chk({tag, "_errcnt"}, 32'(bus.err_cnt), 32'(errs));
    chk({tag, "_pass"},   32'(bus.pass), 32'(errs == 0));
    if (errs != 0) chk({tag, "_first"}, 32'(bus.first_fail), 32'(ff));
`ifdef GATE_SEQ_SIGNATURE_EN
    chk({tag, "_sig"}, 32'(bus.sig_o), 32'(sig));
`endif
    // DONE is sticky while idle
    @(negedge clk);
    chk({tag, "_done_hold"}, 32'(bus.done), 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    gate_fn   = T;
    #2;
    chk_reset("por");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("idle");

    sweep("and",    4'b1000, 1'b0);
    sweep("tie0",   4'b0000, 1'b0);
    sweep("tie1",   4'b1111, 1'b1);
    sweep("and2",   4'b1000, 1'b0);
    sweep("flip0",  4'b1001, 1'b0);
    sweep("flip3",  4'b0000, 1'b1);
    for (int r = 0; r < 6; r++)
      sweep("rnd", N'($urandom_range(0, (1 << N) - 1)), r[0]);

    // reset while vector 2 is applied
    gate_fn = 4'b0110;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_vec2", 32'(bus.vec_o), 2);
    chk("mid_err",  32'(bus.err_cnt), 1);
    rst_n = 1'b0;
    #1;
    chk_reset("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk_reset("post_rst");

    sweep("after_rst", 4'b1000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
